// File: rtl/aes_pkg.sv
// aes_pkg: shared AES block-size, chaining-mode encodings and sequencer FSM states.
package aes_pkg;
    localparam int AES_BLK_W = 128;
    localparam logic [2:0] MODE_ECB = 3'd0;
    localparam logic [2:0] MODE_CBC = 3'd1;
    localparam logic [2:0] MODE_CFB = 3'd2;
    localparam logic [2:0] MODE_OFB = 3'd3;
    localparam logic [2:0] MODE_CTR = 3'd4;
    typedef enum logic [2:0] {S_IDLE, S_WAIT_IN, S_LOAD, S_RUN, S_OUT} state_t;
    function automatic logic mode_legal(input logic [2:0] m);
        return m <= MODE_CTR;
    endfunction
endpackage

// File: rtl/aes_chain_datapath.sv
// aes_chain_datapath: chaining-mode datapath owning feedback, counter and plaintext registers.
//   init      : load fb and ctr from iv (message start)
//   load      : capture in_data as pt and register the mode-selected core_din
//   update    : register out_data from core_dout and advance fb/ctr per mode
//   mode      : latched chaining mode
//   core_din  : registered block presented to the AES core
//   out_data  : registered ciphertext block
module aes_chain_datapath
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic                 load,
    input  logic                 update,
    input  logic [2:0]           mode,
    input  logic [AES_BLK_W-1:0] iv,
    input  logic [AES_BLK_W-1:0] in_data,
    input  logic [AES_BLK_W-1:0] core_dout,
    output logic [AES_BLK_W-1:0] core_din,
    output logic [AES_BLK_W-1:0] out_data
);
    logic [AES_BLK_W-1:0] fb, ctr, pt, din_sel, ks_x, out_sel, fb_sel;

    // Stream modes (CFB/OFB/CTR) encrypt the feedback or counter and mask pt afterwards.
    always_comb begin
        din_sel = mode == MODE_ECB ? in_data :
                  mode == MODE_CBC ? in_data ^ fb :
                  mode == MODE_CTR ? ctr : fb;
        ks_x    = core_dout ^ pt;
        out_sel = (mode == MODE_ECB || mode == MODE_CBC) ? core_dout : ks_x;
        fb_sel  = (mode == MODE_CBC || mode == MODE_OFB) ? core_dout :
                  mode == MODE_CFB ? ks_x : fb;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fb       <= '0;
            ctr      <= '0;
            pt       <= '0;
            core_din <= '0;
            out_data <= '0;
        end else begin
            if (init) begin
                fb  <= iv;
                ctr <= iv;
            end
            if (load) begin
                pt       <= in_data;
                core_din <= din_sel;
            end
            if (update) begin
                out_data <= out_sel;
                fb       <= fb_sel;
                if (mode == MODE_CTR)
                    ctr <= ctr + AES_BLK_W'(1);
            end
        end
    end
endmodule

// File: rtl/aes_block_sequencer.sv
// aes_block_sequencer: sequences a multi-block AES-128 message through one single-block core.
//   cfg_start/cfg_mode/cfg_iv/cfg_nblocks : message configuration, sampled on cfg_start in IDLE
//   busy                                  : message in progress
//   in_valid/in_ready/in_data             : plaintext stream
//   core_start/core_din                   : core request (one-cycle pulse, registered block)
//   core_done/core_dout                   : core completion (one-cycle pulse)
//   out_valid/out_ready/out_data/out_last : ciphertext stream
//   done/err                              : end-of-message or rejected-start pulse; err on illegal mode
module aes_block_sequencer
    import aes_pkg::*;
#(
    parameter int NB_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_start,
    input  logic [2:0]           cfg_mode,
    input  logic [AES_BLK_W-1:0] cfg_iv,
    input  logic [NB_W-1:0]      cfg_nblocks,
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] in_data,
    output logic                 core_start,
    output logic [AES_BLK_W-1:0] core_din,
    input  logic                 core_done,
    input  logic [AES_BLK_W-1:0] core_dout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] out_data,
    output logic                 out_last,
    output logic                 done,
    output logic                 err
);
    state_t          state, state_n;
    logic [2:0]      mode;
    logic [NB_W-1:0] rem;
    logic            done_q, err_q;
    logic            accept, reject, reject_err, load, update, out_hs, fin;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            mode   <= MODE_ECB;
            rem    <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            done_q <= reject || fin;
            err_q  <= reject_err;
            if (accept) begin
                mode <= cfg_mode;
                rem  <= cfg_nblocks;
            end else if (out_hs) begin
                rem <= rem - NB_W'(1);
            end
        end
    end

    always_comb begin
        state_n    = state;
        accept     = 1'b0;
        reject     = 1'b0;
        reject_err = 1'b0;
        load       = 1'b0;
        update     = 1'b0;
        out_hs     = 1'b0;
        fin        = 1'b0;
        case (state)
            S_IDLE: if (cfg_start) begin
                // An illegal mode wins over a zero block count and also raises err.
                reject_err = !mode_legal(cfg_mode);
                reject     = reject_err || cfg_nblocks == '0;
                accept     = !reject;
                state_n    = reject ? S_IDLE : S_WAIT_IN;
            end
            S_WAIT_IN: begin
                load    = in_valid;
                state_n = in_valid ? S_LOAD : S_WAIT_IN;
            end
            S_LOAD: state_n = S_RUN;
            S_RUN: begin
                update  = core_done;
                state_n = core_done ? S_OUT : S_RUN;
            end
            S_OUT: begin
                out_hs  = out_ready;
                fin     = out_ready && rem == NB_W'(1);
                state_n = fin ? S_IDLE : out_ready ? S_WAIT_IN : S_OUT;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign busy       = state != S_IDLE;
    assign in_ready   = state == S_WAIT_IN;
    assign core_start = state == S_LOAD;
    assign out_valid  = state == S_OUT;
    assign out_last   = out_valid && rem == NB_W'(1);
    assign done       = done_q;
    assign err        = err_q;

    aes_chain_datapath u_dp (
        .clk       (clk),
        .reset     (reset),
        .init      (accept),
        .load      (load),
        .update    (update),
        .mode      (mode),
        .iv        (cfg_iv),
        .in_data   (in_data),
        .core_dout (core_dout),
        .core_din  (core_din),
        .out_data  (out_data)
    );
endmodule
